// File: rtl/mult_pipe_pkg.sv
// Shared types and helpers for the pipelined array multiplier.
// The payload carries the widest legal operands; each instance uses only its low WIDTH bits.
package mult_pipe_pkg;

  localparam int MAX_WIDTH      = 128;
  localparam int DEFAULT_STAGES = 4;
  localparam int LATENCY        = DEFAULT_STAGES + 1;

  function automatic int rows_per_stage(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int pipe_latency(input int stages);
    return stages + 1;
  endfunction

  typedef struct packed {
    logic                       valid;
    logic                       mode;
    logic                       acc_clr;
    logic [MAX_WIDTH-1:0]       a;
    logic [MAX_WIDTH-1:0]       b;
    logic [2*MAX_WIDTH-1:0]     sum;
  } stage_t;

endpackage

// File: rtl/mult_pipe_stage.sv
// One array stage: adds this stage's group of partial-product rows to the running sum.
// In signed mode the top row carries negative weight, so it is subtracted.
module mult_pipe_stage
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  stage_t in_p,
  output stage_t out_p
);

  localparam int ROWS = rows_per_stage(WIDTH, STAGES);
  localparam int LO   = IDX * ROWS;
  localparam int HI   = (LO + ROWS > WIDTH) ? WIDTH : LO + ROWS;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] row;
  logic [2*WIDTH-1:0] grp;
  stage_t             nxt;

  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
  always_comb begin
    a_ext = '0;
    row   = '0;
    grp   = '0;
    nxt   = in_p;
    if (in_p.mode) a_ext = {{WIDTH{in_p.a[WIDTH-1]}}, in_p.a[WIDTH-1:0]};
    else           a_ext = {{WIDTH{1'b0}}, in_p.a[WIDTH-1:0]};
    for (int r = 0; r < WIDTH; r++) begin
      if (r >= LO && r < HI && in_p.b[r]) begin
        row = a_ext << r;
        if (in_p.mode && r == WIDTH - 1) row = -row;
        grp = grp + row;
      end
    end
    nxt.sum[2*WIDTH-1:0] = in_p.sum[2*WIDTH-1:0] + grp;
  end

  // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_p <= '0;
    else if (!stall) out_p <= nxt;
  end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned array multiplier: input register, STAGES array stages, output register.
// Optional output accumulator enabled by defining MULT_PIPE_ACC_EN.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
`ifdef MULT_PIPE_ACC_EN
  input  logic               acc_clr,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y
);

  logic               stall;
  stage_t             in_d;
  stage_t             pipe [0:STAGES];
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] y_q;
  logic               unused_bits;

  // A bubble at the output never stalls; only an unconsumed product does.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    in_d                = '0;
    in_d.valid          = in_valid;
    in_d.mode           = signed_mode;
    in_d.a[WIDTH-1:0]   = a;
    in_d.b[WIDTH-1:0]   = b;
`ifdef MULT_PIPE_ACC_EN
    in_d.acc_clr        = acc_clr;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pipe[0] <= '0;
    else if (!stall) pipe[0] <= in_d;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    mult_pipe_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (g)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .in_p  (pipe[g]),
      .out_p (pipe[g+1])
    );
  end

  assign prod = pipe[STAGES].sum[2*WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_q       <= '0;
    end else if (!stall) begin
      out_valid <= pipe[STAGES].valid;
      if (pipe[STAGES].valid) begin
`ifdef MULT_PIPE_ACC_EN
        y_q <= pipe[STAGES].acc_clr ? prod : y_q + prod;
`else
        y_q <= prod;
`endif
      end
    end
  end

  assign y = y_q;

  // Upper payload bits beyond WIDTH are never consumed at the end of the pipe.
  assign unused_bits = ^pipe[STAGES];

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe (WIDTH=8, STAGES=4) against an arithmetic reference model.
// Exercises the accumulator when compiled with MULT_PIPE_ACC_EN.
module tb_mult_pipe;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           signed_mode;
`ifdef MULT_PIPE_ACC_EN
  logic           acc_clr;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2*W-1:0] y;
    int             acc_cyc;
    int             stalls;
    bit             seen;
  } exp_t;

  exp_t           q[$];
  int             cyc       = 0;
  int             stall_cnt = 0;
  int             delivered = 0;
  int             accepted  = 0;
  bit             prev_stall = 0;
  logic [2*W-1:0] prev_y    = '0;
  logic [2*W-1:0] acc_model = '0;

  mult_pipe #(.WIDTH(W), .STAGES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
`ifdef MULT_PIPE_ACC_EN
    .acc_clr     (acc_clr),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input bit mode);
    longint pa, pb;
    if (mode) begin
      pa = $signed(ra);
      pb = $signed(rb);
    end else begin
      pa = ra;
      pb = rb;
    end
    return (2*W)'(pa * pb);
  endfunction

  // Reference model and per-cycle compare, sampled mid-cycle while everything is stable.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [2*W-1:0] p;
    bit             stall_now;
    bit             clr;
    if (!rst_n) begin
      q.delete();
      prev_stall = 0;
      acc_model  = '0;
      check("rst_out_valid", out_valid, 0);
    end else begin
      stall_now = out_valid && !out_ready;
      check("in_ready", in_ready, !stall_now);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_y", y, prev_y);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("stale_out", out_valid, 0);
        end else begin
          check("y", y, q[0].y);
          if (!q[0].seen) begin
            q[0].seen = 1;
            if (q[0].stalls == stall_cnt) check("latency", cyc - q[0].acc_cyc, 5);
          end
          if (out_ready) begin
            void'(q.pop_front());
            delivered++;
          end
        end
      end
      if (stall_now) stall_cnt++;
      if (in_valid && in_ready) begin
        p = ref_mul(a, b, signed_mode);
        clr = 1'b1;
`ifdef MULT_PIPE_ACC_EN
        clr = acc_clr;
`endif
        acc_model = clr ? p : acc_model + p;
        q.push_back('{y: acc_model, acc_cyc: cyc + 1, stalls: stall_cnt, seen: 0});
        accepted++;
      end
      prev_stall = stall_now;
      prev_y     = y;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit m,
                       input bit clr);
    a           = ta;
    b           = tb;
    signed_mode = m;
`ifdef MULT_PIPE_ACC_EN
    acc_clr     = clr;
`else
    if (clr) a = ta;
`endif
  endtask

  task automatic wait_out(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit m,
                          input logic [2*W-1:0] exp, input string name);
    int n;
    out_ready = 1'b1;
    drive(ta, tb, m, 1'b1);
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    wait_out(n);
    check({name, "_latency"}, n, 5);
    check(name, y, exp);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int base_d;
    int base_a;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_y", y, 0);
    next_cycle();
    rst_n = 1'b1;

    directed(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255x255");
    directed(8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128x127");
    directed(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1xm1");
    directed(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
    directed(8'h00, 8'hA5, 1'b0, 16'h0000, "u_zero");

    // Back-to-back stream, one product per cycle.
    base_d = delivered;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      in_valid = 1'b1;
      next_cycle();
    end
    in_valid = 1'b0;
    repeat (10) next_cycle();
    check("stream_count", delivered - base_d, 20);
    check("stream_drained", q.size(), 0);

    // Backpressure on a full pipeline.
    base_d = delivered;
    base_a = accepted;
    for (int i = 0; i < 12; i++) begin
      if (i == 7) check("bp_in_ready", in_ready, 0);
      out_ready = !(i >= 6 && i < 9);
      drive(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      in_valid = 1'b1;
      next_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) next_cycle();
    check("bp_no_loss", delivered - base_d, accepted - base_a);
    check("bp_drained", q.size(), 0);

    // Reset with three products in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      in_valid = 1'b1;
      next_cycle();
    end
    in_valid = 1'b0;
    wait_out(n);
    check("rst_inflight_seen", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_in_ready", in_ready, 1);
    check("rst_async_y", y, 0);
    repeat (2) next_cycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(8'd7, 8'd9, 1'b0, 1'b1);
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    wait_out(n);
    check("post_rst_latency", n, 5);
    check("post_rst_y", y, 63);
    repeat (8) next_cycle();
    check("post_rst_drained", q.size(), 0);

`ifdef MULT_PIPE_ACC_EN
    begin
      logic [2*W-1:0] got [3];
      int k;
      k = 0;
      out_ready = 1'b1;
      drive(8'd3, 8'd4, 1'b0, 1'b1); in_valid = 1'b1; next_cycle();
      drive(8'd5, 8'd6, 1'b0, 1'b0); next_cycle();
      drive(8'd2, 8'd2, 1'b0, 1'b0); next_cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && k < 3; i++) begin
        if (out_valid) begin
          got[k] = y;
          k++;
        end
        next_cycle();
      end
      check("acc_count", k, 3);
      check("acc_0", got[0], 12);
      check("acc_1", got[1], 42);
      check("acc_2", got[2], 46);
    end
`endif

    repeat (4) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, legal range 2..128.
REQ-002 SHALL have parameter STAGES, default 4: pipeline stages in the array, legal range 1..WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  pipeline accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-010 SHALL have port out_valid  output  1  y holds a finished product.
REQ-011 SHALL have port out_ready  input  1  consumer takes y this cycle.
REQ-012 SHALL have port y  output  2*WIDTH  product.

Function
REQ-013 SHALL accept a transfer when in_valid && in_ready; a, b, signed_mode registered into the input stage.
REQ-014 SHALL split the WIDTH partial-product rows into STAGES groups of ceil(WIDTH/STAGES) rows; last group takes the remainder.
REQ-015 SHALL add one group per stage to a registered 2*WIDTH running sum, carrying operands, mode and a valid bit forward with it.
REQ-016 SHALL deliver y exactly STAGES+1 cycles after acceptance when no stall occurs.
REQ-017 SHALL produce y = a*b mod 2^(2*WIDTH) unsigned when signed_mode=0, and the exact two's-complement 2*WIDTH product when signed_mode=1.
REQ-018 SHALL stall globally: stall = out_valid && !out_ready; during stall every stage register, including y, holds.
REQ-019 SHALL drive in_ready = !stall, combinationally.
REQ-020 SHALL sustain one product per cycle when out_ready is held high.
REQ-021 SHALL advance bubbles (valid=0) like data; a bubble at the output with out_ready=0 causes no stall.
REQ-022 SHALL hold y stable and out_valid high until out_ready is seen.
REQ-023 SHALL keep mode per transaction: consecutive products with different signed_mode do not interfere.

Reset
REQ-024 SHALL, on rst_n low, immediately clear all valid bits, out_valid=0, in_ready=1, y=0, all sums 0.
REQ-025 SHALL discard in-flight products on reset mid-operation; no output appears for them after release.
REQ-026 SHALL accept new operands on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with MULT_PIPE_ACC_EN defined, add input acc_clr (1 bit, sampled with a/b) and an output accumulator: each delivered product is added to the 2*WIDTH accumulator (wrapping), y shows the accumulator, and acc_clr=1 makes that transaction load the product instead of adding.
REQ-028 SHALL advance the accumulator only when a valid product leaves the last array stage, never during stall; accumulator resets to 0.
REQ-029 SHALL, without MULT_PIPE_ACC_EN, have no acc_clr port and no accumulator; latency unchanged in both builds.

Structure
REQ-030 SHALL place in package mult_pipe_pkg: the rows-per-stage function, the latency constant (STAGES+1), and the stage payload typedef (valid, mode, acc_clr, operands, sum).
REQ-031 SHALL use one sub-module mult_pipe_stage (adds one row group, holds on stall), instantiated STAGES times by generate.

Verification
REQ-032 SHALL check, with WIDTH=8, STAGES=4, unsigned: a=255, b=255 -> y=65025 (0xFE01) with out_valid exactly 5 cycles after acceptance.
REQ-033 SHALL check signed mode at WIDTH=8: a=0x80, b=0x7F -> y=0xC080 (-16256); a=0xFF, b=0xFF -> y=0x0001.
REQ-034 SHALL check back-to-back streaming of 20 random pairs with out_ready=1 -> one result per cycle, in order, all matching a reference model.
REQ-035 SHALL check backpressure: out_ready=0 for 3 cycles with a full pipeline -> in_ready=0, y held, no loss or duplication after release.
REQ-036 SHALL check reset asserted with 3 products in flight -> out_valid=0 at once, no stale output after release; next product correct.
REQ-037 SHALL check, with MULT_PIPE_ACC_EN: products 3*4 (acc_clr=1), then 5*6, then 2*2 -> y sequence 12, 42, 46.
